// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types: response codes, bus widths and the responder FSM states.
package axi4lite_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ALEN = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_DATA = 2'b10
    } r_state_t;

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4lite;
    import axi4lite_pkg::*;

    logic              awvalid;
    logic              awready;
    logic [ALEN-1:0]   awaddr;
    logic              wvalid;
    logic              wready;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ALEN-1:0]   araddr;
    logic              rvalid;
    logic              rready;
    logic [XLEN-1:0]   rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/sram_1rw_be.sv
// One-read one-write synchronous RAM with per-byte write enables and a one-cycle
// registered read; a same-edge read of the word being written returns old data.
module sram_1rw_be #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned DW    = 64,
    parameter int unsigned AW    = $clog2(WORDS),
    parameter int unsigned NB    = DW / 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [NB-1:0] be_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [WORDS];
    logic [DW-1:0] rdata_q;

    // Storage is deliberately unreset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
        if (we_i) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be_i[i]) begin
                    mem[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4lite_sram.sv
// AXI4-Lite responder over an on-chip SRAM, independent single-outstanding read/write.
// Optional AXI_SRAM_RANGE_CHECK_EN: SLVERR on out-of-window or misaligned accesses.
module axi4lite_sram
    import axi4lite_pkg::*;
#(
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [ALEN-1:0] BASE_ADDR = '0
) (
    input  logic   clk,
    input  logic   rst,
    axi4lite.slave sys_bus
);

    localparam int unsigned     NB    = XLEN / 8;
    localparam int unsigned     OFF_W = $clog2(NB);
    localparam int unsigned     IDX_W = $clog2(DEPTH);
    localparam logic [ALEN-1:0] SPAN  = ALEN'(DEPTH * NB);

    function automatic logic [IDX_W-1:0] word_idx(input logic [ALEN-1:0] a);
        logic [ALEN-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    w_state_t        w_state_q, w_state_d;
    logic            awready_q, awready_d, wready_q, wready_d;
    logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ALEN-1:0] awaddr_q, awaddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NB-1:0]   wstrb_q, wstrb_d;
    logic            bvalid_q, bvalid_d;
    axi_resp_t       bresp_q, bresp_d;

    r_state_t        r_state_q, r_state_d;
    logic            arready_q, arready_d;
    logic            rerr_q, rerr_d;
    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    axi_resp_t       rresp_q, rresp_d;

    logic            aw_hs, w_hs, ar_hs, w_err, r_err;
    logic [ALEN-1:0] aw_addr_eff;
    logic [XLEN-1:0] w_data_eff;
    logic [NB-1:0]   w_strb_eff;
    logic            ram_we, ram_re;
    logic [NB-1:0]   ram_be;
    logic [XLEN-1:0] ram_rdata;

    assign aw_hs       = sys_bus.awvalid && awready_q;
    assign w_hs        = sys_bus.wvalid  && wready_q;
    assign ar_hs       = sys_bus.arvalid && arready_q;
    assign aw_addr_eff = aw_hs ? sys_bus.awaddr : awaddr_q;
    assign w_data_eff  = w_hs  ? sys_bus.wdata  : wdata_q;
    assign w_strb_eff  = w_hs  ? sys_bus.wstrb  : wstrb_q;

    // Access legality; a write is misaligned only when it claims the full word.
    always_comb begin
`ifdef AXI_SRAM_RANGE_CHECK_EN
        w_err = ((aw_addr_eff - BASE_ADDR) >= SPAN) ||
                ((&w_strb_eff) && (aw_addr_eff[OFF_W-1:0] != '0));
        r_err = ((sys_bus.araddr - BASE_ADDR) >= SPAN) ||
                (sys_bus.araddr[OFF_W-1:0] != '0);
`else
        w_err = 1'b0;
        r_err = 1'b0;
`endif
    end

    // Write FSM: collect AW and W in any order, commit on the edge both are held.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ram_we    = 1'b0;
        ram_be    = '0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = sys_bus.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = sys_bus.wdata;
                    wstrb_d  = sys_bus.wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    ram_we    = !w_err;
                    ram_be    = w_err ? '0 : w_strb_eff;
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = w_err ? SLVERR : OKAY;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else begin
                    awready_d = !(aw_held_q || aw_hs);
                    wready_d  = !(w_held_q || w_hs);
                end
            end
            W_RESP: begin
                if (sys_bus.bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: the RAM is addressed straight from AR so data lands during R_WAIT.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rerr_d    = rerr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ram_re    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    ram_re    = 1'b1;
                    rerr_d    = r_err;
                    arready_d = 1'b0;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                r_state_d = R_DATA;
                rvalid_d  = 1'b1;
                rdata_d   = rerr_q ? '0 : ram_rdata;
                rresp_d   = rerr_q ? SLVERR : OKAY;
            end
            R_DATA: begin
                if (sys_bus.rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rerr_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rerr_q    <= rerr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    sram_1rw_be #(
        .WORDS (DEPTH),
        .DW    (XLEN)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (word_idx(aw_addr_eff)),
        .wdata_i (w_data_eff),
        .be_i    (ram_be),
        .re_i    (ram_re),
        .raddr_i (word_idx(sys_bus.araddr)),
        .rdata_o (ram_rdata)
    );

    assign sys_bus.awready = awready_q;
    assign sys_bus.wready  = wready_q;
    assign sys_bus.bvalid  = bvalid_q;
    assign sys_bus.bresp   = bresp_q;
    assign sys_bus.arready = arready_q;
    assign sys_bus.rvalid  = rvalid_q;
    assign sys_bus.rdata   = rdata_q;
    assign sys_bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axi4lite_sram.sv
// Directed bench for axi4lite_sram: handshakes, strobes, backpressure, hazards, reset.
module tb_axi4lite_sram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    axi4lite bus ();

    axi4lite_sram #(
        .DEPTH     (1024),
        .BASE_ADDR (32'h8000_0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sys_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, aw_acc, w_acc;
        ok = 1'b0; resp = 2'b11; aw_done = 1'b0; w_done = 1'b0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_acc = bus.awvalid && bus.awready;
            w_acc  = bus.wvalid && bus.wready;
            tick();
            if (aw_acc) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
            if (w_acc)  begin w_done = 1'b1;  bus.wvalid = 1'b0;  end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (aw_done && w_done) begin
            bus.bready = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (bus.bvalid) begin
                    resp = bus.bresp; ok = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
            bus.bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [63:0] data,
                            output logic [1:0] resp, output int lat, output bit ok);
        bit acc;
        ok = 1'b0; lat = 0; data = '0; resp = 2'b11; acc = 1'b0;
        bus.araddr = addr; bus.arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc = bus.arready;
            tick();
            if (acc) break;
        end
        bus.arvalid = 1'b0;
        if (acc) begin
            bus.rready = 1'b1;
            for (int i = 0; i < 20; i++) begin
                lat++;
                if (bus.rvalid) begin
                    data = bus.rdata; resp = bus.rresp; ok = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
            bus.rready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        vectors++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", bus.awready); end
        vectors++; if (bus.wready  !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", bus.wready); end
        vectors++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", bus.arready); end
        vectors++; if (bus.bvalid  !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", bus.bvalid); end
        vectors++; if (bus.rvalid  !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", bus.rvalid); end
        vectors++; if (bus.bresp !== 2'b00 || bus.rresp !== 2'b00) begin errors++; $display("FAIL rst_resp got %b/%b want 00/00", bus.bresp, bus.rresp); end
        vectors++; if (bus.rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
        rst = 1'b0;
        tick();
        vectors++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin errors++; $display("FAIL rst_release_readies got %b want 111", {bus.awready, bus.wready, bus.arready}); end
    endtask

    task automatic test_basic;
        logic [63:0] d; logic [1:0] r; int lat; bit ok;
        axi_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, r, ok);
        vectors++; if (ok !== 1'b1 || r !== 2'b00) begin errors++; $display("FAIL basic_bresp got ok=%b resp=%b want ok=1 resp=00", ok, r); end
        axi_read(32'h8000_0010, d, r, lat, ok);
        vectors++; if (ok !== 1'b1 || d !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL basic_rdata got %h want 1122334455667788", d); end
        vectors++; if (r !== 2'b00) begin errors++; $display("FAIL basic_rresp got %b want 00", r); end
        vectors++; if (lat !== 2) begin errors++; $display("FAIL basic_rlat got %0d want 2", lat); end
    endtask

    task automatic test_w_before_aw;
        logic [63:0] d; logic [1:0] r; int lat; bit ok;
        bus.wdata = 64'hAAAA_AAAA_AAAA_AAAA; bus.wstrb = 8'h0F; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        vectors++; if ({bus.awready, bus.wready, bus.bvalid} !== 3'b100) begin errors++; $display("FAIL wfirst_held got aw/w/b=%b want 100", {bus.awready, bus.wready, bus.bvalid}); end
        tick(); tick();
        bus.awaddr = 32'h8000_0010; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        vectors++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin errors++; $display("FAIL wfirst_bvalid got %b/%b want 1/00", bus.bvalid, bus.bresp); end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        vectors++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_bdone got %b want 0", bus.bvalid); end
        axi_read(32'h8000_0010, d, r, lat, ok);
        vectors++; if (ok !== 1'b1 || d !== 64'h1122_3344_AAAA_AAAA) begin errors++; $display("FAIL wfirst_merge got %h want 11223344aaaaaaaa", d); end
    endtask

    task automatic test_backpressure;
        logic [63:0] d; logic [1:0] r; int lat; bit ok;
        bus.awaddr = 32'h8000_0030; bus.wdata = 64'hCAFE_F00D_1234_5678; bus.wstrb = 8'hFF;
        bus.araddr = 32'h8000_0010;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin errors++; $display("FAIL bp_b cyc%0d got %b/%b want 1/00", i, bus.bvalid, bus.bresp); end
            vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== 64'h1122_3344_AAAA_AAAA) begin errors++; $display("FAIL bp_r cyc%0d got %b/%h want 1/11223344aaaaaaaa", i, bus.rvalid, bus.rdata); end
            vectors++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin errors++; $display("FAIL bp_readies cyc%0d got %b want 000", i, {bus.awready, bus.wready, bus.arready}); end
            tick();
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        vectors++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin errors++; $display("FAIL bp_release_valids got %b want 00", {bus.bvalid, bus.rvalid}); end
        vectors++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin errors++; $display("FAIL bp_release_readies got %b want 111", {bus.awready, bus.wready, bus.arready}); end
        axi_read(32'h8000_0030, d, r, lat, ok);
        vectors++; if (ok !== 1'b1 || d !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("FAIL bp_wdata got %h want cafef00d12345678", d); end
    endtask

    task automatic test_same_edge;
        logic [63:0] d, rd; logic [1:0] r; int lat; bit ok, got, bgot;
        axi_write(32'h8000_0020, 64'h5, 8'hFF, r, ok);
        got = 1'b0; bgot = 1'b0; rd = '0;
        bus.awaddr = 32'h8000_0020; bus.wdata = 64'h9; bus.wstrb = 8'hFF; bus.araddr = 32'h8000_0020;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.rvalid && !got) begin rd = bus.rdata; got = 1'b1; end
            if (bus.bvalid) bgot = 1'b1;
            tick();
        end
        bus.bready = 1'b0; bus.rready = 1'b0;
        vectors++; if (got !== 1'b1 || bgot !== 1'b1 || rd !== 64'h5) begin errors++; $display("FAIL rbw_old got r=%b b=%b data=%h want 1/1/5", got, bgot, rd); end
        axi_read(32'h8000_0020, d, r, lat, ok);
        vectors++; if (ok !== 1'b1 || d !== 64'h9) begin errors++; $display("FAIL rbw_new got %h want 9", d); end
    endtask

    task automatic test_range;
        logic [63:0] d; logic [1:0] r; int lat; bit ok;
        axi_write(32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, r, ok);
        axi_read(32'h8000_2000, d, r, lat, ok);
`ifdef AXI_SRAM_RANGE_CHECK_EN
        vectors++; if (ok !== 1'b1 || r !== 2'b10 || d !== 64'h0) begin errors++; $display("FAIL range_oob got resp=%b data=%h want 10/0", r, d); end
        axi_read(32'h8000_0004, d, r, lat, ok);
        vectors++; if (ok !== 1'b1 || r !== 2'b10 || d !== 64'h0) begin errors++; $display("FAIL range_misalign got resp=%b data=%h want 10/0", r, d); end
`else
        vectors++; if (ok !== 1'b1 || r !== 2'b00 || d !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL range_wrap got resp=%b data=%h want 00/0123456789abcdef", r, d); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [63:0] d; logic [1:0] r; int lat; bit ok;
        bus.awaddr = 32'h8000_0050; bus.wdata = 64'h7777; bus.wstrb = 8'hFF; bus.araddr = 32'h8000_0010;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin errors++; $display("FAIL midrst_valids got %b want 00", {bus.bvalid, bus.rvalid}); end
        vectors++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin errors++; $display("FAIL midrst_readies got %b want 000", {bus.awready, bus.wready, bus.arready}); end
        tick();
        vectors++; if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin errors++; $display("FAIL midrst_hold got %b want 00000", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}); end
        rst = 1'b0;
        tick();
        vectors++; if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin errors++; $display("FAIL midrst_release got %b want 11100", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}); end
        axi_read(32'h8000_0010, d, r, lat, ok);
        vectors++; if (ok !== 1'b1 || r !== 2'b00 || d !== 64'h1122_3344_AAAA_AAAA) begin errors++; $display("FAIL midrst_keep10 got %h want 11223344aaaaaaaa", d); end
        axi_read(32'h8000_0020, d, r, lat, ok);
        vectors++; if (ok !== 1'b1 || d !== 64'h9) begin errors++; $display("FAIL midrst_keep20 got %h want 9", d); end
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_backpressure();
        test_same_edge();
        test_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
